// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-cycle EXEC for add/sub/logic/shift ops, shift-add MUL over DATAWIDTH cycles.
// Latency: done pulses 2 cycles after start (1 + DATAWIDTH for MUL); F/FLAG registered, held between ops.
// Backpressure: start is sampled only while idle (busy low); requests while busy are dropped.
module alu_mc #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           ALU_OP,
    input  logic [DATAWIDTH-1:0] dst,
    input  logic [DATAWIDTH-1:0] src,
    input  logic                 flag_en,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] F,
    output logic [3:0]           FLAG
);
    localparam int W  = DATAWIDTH;
    localparam int CW = $clog2(W);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDC = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SUBB = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_INC  = 4'd9;
    localparam logic [3:0] OP_DEC  = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t         state;
    logic [3:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           cin_q;
    logic           fen_q;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] prod;
    logic [CW-1:0]  cnt;

    logic [W-1:0]   bp;
    logic           c0;
    logic [W:0]     sum;
    logic [W-1:0]   res_f;
    logic           res_c;
    logic           res_o;
    logic           upd;

    assign busy = (state != IDLE);
    // b_q doubles as the multiplier shift register while in MUL
    assign prod = acc + (b_q[0] ? mcand : '0);

    always_comb begin
        bp    = '0;
        c0    = 1'b0;
        res_f = '0;
        res_c = 1'b0;
        res_o = 1'b0;
        upd   = 1'b1;
        case (op_q)
            OP_ADD:  bp = b_q;
            OP_ADDC: begin bp = b_q;  c0 = cin_q; end
            OP_SUB:  begin bp = ~b_q; c0 = 1'b1;  end
            OP_SUBB: begin bp = ~b_q; c0 = cin_q; end
            OP_INC:  c0 = 1'b1;
            OP_DEC:  bp = '1;
            default: bp = '0;
        endcase
        sum = {1'b0, a_q} + {1'b0, bp} + {{W{1'b0}}, c0};
        case (op_q)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBB, OP_INC, OP_DEC: begin
                res_f = sum[W-1:0];
                res_c = sum[W];
                res_o = (a_q[W-1] == bp[W-1]) && (sum[W-1] != a_q[W-1]);
            end
            OP_AND:  res_f = a_q & b_q;
            OP_OR:   res_f = a_q | b_q;
            OP_NOT:  res_f = ~a_q;
            OP_XOR:  res_f = a_q ^ b_q;
            OP_SHL:  begin res_f = {a_q[W-2:0], 1'b0}; res_c = a_q[W-1]; end
            OP_SHR:  begin res_f = {1'b0, a_q[W-1:1]}; res_c = a_q[0];   end
            default: upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            F     <= '0;
            FLAG  <= 4'b0000;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            fen_q <= 1'b0;
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= ALU_OP;
                        a_q   <= dst;
                        b_q   <= src;
                        fen_q <= flag_en;
                        cin_q <= FLAG[0];
                        acc   <= '0;
                        mcand <= {{W{1'b0}}, dst};
                        cnt   <= '0;
                        state <= (ALU_OP == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    if (upd) begin
                        F <= res_f;
                        if (fen_q)
                            FLAG <= {res_f[W-1], res_f == '0, res_o, res_c};
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                MUL: begin
                    acc   <= prod;
                    mcand <= mcand << 1;
                    b_q   <= b_q >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        F <= prod[W-1:0];
                        if (fen_q)
                            FLAG <= {prod[W-1], prod[W-1:0] == '0, 1'b0, |prod[2*W-1:W]};
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Randomized scoreboard bench for alu_mc: an arithmetic reference model predicts each result at issue,
// a negedge monitor pops and compares result, flags and completion cycle on every done pulse.
module tb_alu_mc;
    localparam int W = 8;

    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, ADDC = 4'd2, SUB = 4'd3,
                           XOR = 4'd8, MUL = 4'd13;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   alu_op;
    logic [W-1:0] dst;
    logic [W-1:0] src;
    logic         flag_en;
    logic         busy;
    logic         done;
    logic [W-1:0] f;
    logic [3:0]   flag;

    alu_mc #(.DATAWIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .ALU_OP(alu_op), .dst(dst), .src(src),
        .flag_en(flag_en), .busy(busy), .done(done), .F(f), .FLAG(flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] f;
        logic [3:0]   flag;
        int           due;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passed = 0;

    logic [W-1:0] mf;
    logic [3:0]   mflag;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endfunction

    // Reference model: signed/unsigned integer arithmetic, updates the model's F/FLAG view.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic fen);
        int  ua, ub, sa, sb_, us, ss, r, cin, half, full;
        bit  arith, upd, c, o;
        logic [W-1:0] rf;
        full  = 1 << W;
        half  = 1 << (W - 1);
        ua    = int'(a);
        ub    = int'(b);
        sa    = (ua >= half) ? ua - full : ua;
        sb_   = (ub >= half) ? ub - full : ub;
        cin   = int'(mflag[0]);
        arith = 1'b0; upd = 1'b1; c = 1'b0; o = 1'b0; us = 0; ss = 0; r = 0;
        case (op)
            4'd1:  begin arith = 1; us = ua + ub;              ss = sa + sb_;           end
            4'd2:  begin arith = 1; us = ua + ub + cin;        ss = sa + sb_ + cin;     end
            4'd3:  begin arith = 1; us = ua - ub + full;       ss = sa - sb_;           end
            4'd4:  begin arith = 1; us = ua - ub - 1 + cin + full; ss = sa - sb_ - 1 + cin; end
            4'd9:  begin arith = 1; us = ua + 1;               ss = sa + 1;             end
            4'd10: begin arith = 1; us = ua + full - 1;        ss = sa - 1;             end
            4'd5:  r = ua & ub;
            4'd6:  r = ua | ub;
            4'd7:  r = (full - 1) - ua;
            4'd8:  r = ua ^ ub;
            4'd11: begin r = (ua * 2) % full; c = (ua >= half); end
            4'd12: begin r = ua / 2;          c = (ua % 2 == 1); end
            4'd13: begin r = (ua * ub) % full; c = ((ua * ub) / full) != 0; end
            default: upd = 1'b0;
        endcase
        if (arith) begin
            r = us % full;
            c = (us >= full);
            o = (ss < -half) || (ss > half - 1);
        end
        if (upd) begin
            rf = W'(r);
            mf = rf;
            if (fen) mflag = {rf >= W'(half), rf == '0, o, c};
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("F", 32'(f), 32'(e.f));
                check("FLAG", 32'(flag), 32'(e.flag));
                check("done_cycle", 32'(cyc), 32'(e.due));
                check("busy_with_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called at a negedge; waits for idle (optionally jamming ignored starts), then issues one op.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic fen, input bit jam);
        exp_t e;
        int   n = 0;
        while (busy) begin
            if (n++ > 200) begin
                check("issue_timeout", 32'(busy), 32'd0);
                start = 1'b0;
                return;
            end
            start   = jam && ($urandom_range(1) == 1);
            alu_op  = 4'($urandom);
            dst     = W'($urandom);
            src     = W'($urandom);
            flag_en = 1'($urandom);
            @(negedge clk);
        end
        start   = 1'b1;
        alu_op  = op;
        dst     = a;
        src     = b;
        flag_en = fen;
        model(op, a, b, fen);
        e.f    = mf;
        e.flag = mflag;
        e.due  = cyc + ((op == MUL) ? 1 + W : 2);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; alu_op = '0; dst = '0; src = '0; flag_en = 1'b0;
        mf = '0; mflag = '0;
        repeat (3) @(negedge clk);
        check("rst_F", 32'(f), 32'd0);
        check("rst_FLAG", 32'(flag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(ADD, 8'h7F, 8'h01, 1'b1, 1'b0);
        drain();
        check("add_ovf_F", 32'(f), 32'h80);
        check("add_ovf_FLAG", 32'(flag), 32'hA);

        issue(XOR, 8'hF0, 8'hFF, 1'b0, 1'b0);
        drain();
        check("xor_noflag_F", 32'(f), 32'h0F);
        check("xor_noflag_FLAG", 32'(flag), 32'hA);

        issue(SUB, 8'h05, 8'h05, 1'b1, 1'b0);
        drain();
        check("sub_zero_F", 32'(f), 32'h00);
        check("sub_zero_FLAG", 32'(flag), 32'h5);

        issue(ADD, 8'hFF, 8'h01, 1'b1, 1'b0);
        issue(ADDC, 8'h10, 8'h20, 1'b1, 1'b0);
        drain();
        check("addc_F", 32'(f), 32'h31);
        check("addc_FLAG", 32'(flag), 32'h0);

        issue(MUL, 8'h10, 8'h20, 1'b1, 1'b0);
        while (busy) begin
            start = 1'b1; alu_op = ADD; dst = 8'h01; src = 8'h01; flag_en = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        drain();
        check("mul_F", 32'(f), 32'h00);
        check("mul_FLAG", 32'(flag), 32'h5);

        issue(ADD, 8'h03, 8'h04, 1'b1, 1'b0);
        issue(NOP, 8'hAA, 8'h55, 1'b1, 1'b0);
        drain();
        check("nop_F", 32'(f), 32'h07);
        check("nop_FLAG", 32'(flag), 32'h0);

        issue(MUL, 8'h33, 8'h07, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        mf = '0; mflag = '0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_F", 32'(f), 32'd0);
        check("abort_FLAG", 32'(flag), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom), W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(1)));
            if ($urandom_range(3) == 0) @(negedge clk);
        end
        drain();
        check("final_F", 32'(f), 32'(mf));
        check("final_FLAG", 32'(flag), 32'(mflag));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
